dmem_lsu: RTL and testbench

Load/store unit between the core's memory stage and the word-only `dmem`. Accepts one RV32I load or store per request, extracts and sign/zero-extends sub-word loads, and implements `sb`/`sh` as a read-modify-write sequence, since `dmem` only writes whole words. It drives `dmem`'s `we`, `a`, `wd` and `pc` inputs and consumes its combinational `rd`. Misaligned and illegal accesses are flagged without touching memory.

---
 rtl/dmem_lsu.sv | 183 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the core memory stage and a word-only dmem.
// Executes one RV32I load or store per request. Sub-word loads are extracted and
// sign/zero-extended; sb/sh are done as read-modify-write because dmem only
// writes whole words. Misaligned or illegal requests answer with an error
// without touching memory.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_funct3    store flag and RV32I funct3
//   req_addr, req_wdata   byte address and store data
//   req_pc                instruction PC forwarded to dmem
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result (0 for stores/errors) and error flag
//   mem_we, mem_a, mem_wd, mem_pc   dmem write enable, word address, data, PC
//   mem_rd                dmem combinational read data
module dmem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_next;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state == WR) & ~reset;
    assign mem_a      = {addr_q[31:2], 2'b00};
    assign mem_wd     = wd_q;
    assign mem_pc     = pc_q;

    // Classification of the incoming request.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane extraction and merge on the word currently read from dmem.
    always_comb begin
        byte_sel = mem_rd[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rd[7:0];
            2'd1: byte_sel = mem_rd[15:8];
            2'd2: byte_sel = mem_rd[23:16];
            2'd3: byte_sel = mem_rd[31:24];
            default: byte_sel = mem_rd[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        load_val = mem_rd;
        case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = mem_rd;
        endcase

        // Only sb (funct3 000) and sh (funct3 001) reach the merge path.
        merged = mem_rd;
        if (!f3_q[0]) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rd;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                     state_next = RESP;
                    else if (!req_we)                state_next = RD;
                    else if (req_funct3 == 3'b010)   state_next = WR;
                    else                             state_next = RD;
                end
            end
            RD:      state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // resp_rdata/resp_err only change on the edge that enters RESP, so they
    // hold their previous values between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        if (req_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            wd_q <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        wd_q <= merged;
                    end else begin
                        rdata_q <= load_val;
                        err_q   <= 1'b0;
                    end
                end
                WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: word-only dmem model plus a byte-level
// reference model of RV32I load/store semantics.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_pc;
    logic [31:0] mem_rd;

    dmem_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_pc     (mem_pc),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // dmem: combinational read, write on falling edge; backdoor for setup.
    logic [31:0] mem [0:15];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;
    assign mem_rd = mem[mem_a[5:2]];
    always @(negedge clk) begin
        if (mem_we) mem[mem_a[5:2]] <= mem_wd;
        else if (bd_we) mem[bd_idx] <= bd_val;
    end

    // Reference memory as individual bytes (little-endian).
    logic [7:0] rb [0:63];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int i);
        return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
    endfunction

    // Entered and left at posedge+1.
    task automatic poke(input int idx, input logic [31:0] val);
        for (int j = 0; j < 4; j++) rb[4*idx+j] = 8'(val >> (8*j));
        bd_idx = 4'(idx);
        bd_val = val;
        bd_we  = 1'b1;
        @(negedge clk); #1;
        bd_we  = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue one request and follow it cycle by cycle; req_valid stays high
    // (with scrambled req_* fields) until the response to test backpressure.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned size, lat, wrk;
        logic        eerr;
        logic [31:0] erdata, v, pc, ewd;
        int          a;
        a    = int'(addr);
        pc   = $urandom;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        eerr = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && f3[2]) ||
               (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'd0);
        erdata = 0;
        wrk    = 0;
        ewd    = 0;
        if (eerr) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            v = 0;
            for (int j = 0; j < int'(size); j++) v += 32'(rb[a+j]) << (8*j);
            if (!f3[2] && size < 4 && v >= (32'd1 << (8*size-1)))
                v = v - (32'd1 << (8*size));
            erdata = v;
        end else begin
            lat = (size == 4) ? 2 : 3;
            wrk = (size == 4) ? 1 : 2;
            for (int j = 0; j < int'(size); j++) rb[a+j] = 8'(wdata >> (8*j));
            ewd = ref_word(a / 4);
        end

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_pc     = pc;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        for (int unsigned k = 1; k <= lat + 1; k++) begin
            if (k == 1) begin
                check("mem_a", mem_a, {addr[31:2], 2'b00});
                check("mem_pc", mem_pc, pc);
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                req_pc     = $urandom;
            end
            check("resp_valid", {31'd0, resp_valid}, {31'd0, k == lat});
            check("mem_we", {31'd0, mem_we}, {31'd0, k == wrk});
            check("req_ready", {31'd0, req_ready}, {31'd0, k == lat + 1});
            if (k == wrk) check("mem_wd", mem_wd, ewd);
            if (k == lat) begin
                check("rdata", resp_rdata, erdata);
                check("err", {31'd0, resp_err}, {31'd0, eerr});
                req_valid = 1'b0;
            end
            if (k <= lat) begin
                @(posedge clk); #1;
            end
        end
        check("ram_word", mem[addr[5:2]], ref_word(int'(addr[5:2])));
    endtask

    initial begin
        logic [31:0] ra;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h4;
        req_wdata  = '0;
        req_pc     = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_mem_pc", mem_pc, 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_resp", {31'd0, resp_valid}, 32'd0);

        for (int i = 0; i < 16; i++) poke(i, $urandom);

        poke(1, 32'h8899AABB);
        do_req(1'b0, 3'b010, 32'h4, 32'h0);
        poke(0, 32'h80FF7F01);
        do_req(1'b0, 3'b000, 32'h1, 32'h0);
        do_req(1'b0, 3'b000, 32'h2, 32'h0);
        do_req(1'b0, 3'b100, 32'h2, 32'h0);
        do_req(1'b0, 3'b001, 32'h2, 32'h0);
        do_req(1'b0, 3'b101, 32'h2, 32'h0);
        poke(2, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h9, 32'h000000A5);
        do_req(1'b0, 3'b010, 32'h8, 32'h0);
        poke(3, 32'hDEADBEEF);
        do_req(1'b1, 3'b001, 32'hE, 32'h00001234);
        do_req(1'b1, 3'b010, 32'hC, 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 32'h6, 32'h0);
        do_req(1'b1, 3'b001, 32'h3, 32'hFFFF);
        do_req(1'b0, 3'b011, 32'h0, 32'h0);
        do_req(1'b1, 3'b100, 32'h0, 32'hFF);

        // Reset during the WR cycle of an sb: no write, no response.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h5A;
        req_pc     = 32'h200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_resp", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        check("abort_ram", mem[0], ref_word(0));

        for (int n = 0; n < 300; n++) begin
            ra = 32'($urandom_range(0, 63));
            do_req(1'($urandom), 3'($urandom), ra, $urandom);
        end

        for (int i = 0; i < 16; i++) check("final_ram", mem[i], ref_word(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
